// File: rtl/mips_debug_pkg.sv
// Shared debug-path definitions: frame header byte, byte width and the
// serializer state encoding.
package mips_debug_pkg;

   localparam int                BYTE_W       = 8;
   localparam logic [BYTE_W-1:0] FRAME_HEADER = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HEADER   = 3'd1,
      ST_PAYLOAD  = 3'd2,
      ST_CHECKSUM = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/reg_dump_serializer.sv
// Snapshots the flat register image on request and streams it as
// header, register bytes (reg 0 first, MSB first), 8-bit checksum.
module reg_dump_serializer
   import mips_debug_pkg::*;
#(
   parameter int SIZE          = 32,
   parameter int NUM_REGISTERS = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic [SIZE*NUM_REGISTERS-1:0] i_registers_debug,
   output logic [BYTE_W-1:0]             o_tx_data,
   output logic                          o_tx_valid,
   input  logic                          i_tx_ready,
   output logic                          o_busy,
   output logic                          o_done
);

   localparam int BYTES_PER_REG = SIZE / BYTE_W;
   localparam int REG_IDX_W     = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
   localparam int BYTE_IDX_W    = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
   localparam logic [REG_IDX_W-1:0]  LAST_REG  = REG_IDX_W'(NUM_REGISTERS - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_REG - 1);

   state_t                        state_q, state_d;
   logic [SIZE*NUM_REGISTERS-1:0] snapshot_q;
   logic [REG_IDX_W-1:0]          reg_idx_q;
   logic [BYTE_IDX_W-1:0]         byte_idx_q;
   logic [BYTE_W-1:0]             checksum_q;
   logic [SIZE-1:0]               cur_reg;
   logic [BYTE_W-1:0]             payload_byte;
   logic                          last_payload;
   logic                          accept;

   always_comb begin
      cur_reg      = snapshot_q[int'(reg_idx_q)*SIZE +: SIZE];
      payload_byte = cur_reg[SIZE-1-BYTE_W*int'(byte_idx_q) -: BYTE_W];
      last_payload = (reg_idx_q == LAST_REG) && (byte_idx_q == LAST_BYTE);
   end

   always_comb begin
      state_d    = state_q;
      o_tx_valid = 1'b0;
      o_tx_data  = '0;
      o_busy     = (state_q != ST_IDLE);
      o_done     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            o_tx_valid = 1'b1;
            o_tx_data  = FRAME_HEADER;
            if (i_tx_ready) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            o_tx_valid = 1'b1;
            o_tx_data  = payload_byte;
            if (i_tx_ready && last_payload) state_d = ST_CHECKSUM;
         end
         ST_CHECKSUM: begin
            o_tx_valid = 1'b1;
            o_tx_data  = checksum_q;
            if (i_tx_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign accept = o_tx_valid && i_tx_ready;

   // Snapshot and counters only move on start in IDLE or on a payload transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         snapshot_q <= '0;
         reg_idx_q  <= '0;
         byte_idx_q <= '0;
         checksum_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && i_start) begin
            snapshot_q <= i_registers_debug;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            checksum_q <= '0;
         end else if (state_q == ST_PAYLOAD && accept) begin
            checksum_q <= checksum_q + payload_byte;
            if (byte_idx_q == LAST_BYTE) begin
               byte_idx_q <= '0;
               reg_idx_q  <= reg_idx_q + 1'b1;
            end else begin
               byte_idx_q <= byte_idx_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Directed bench for reg_dump_serializer: frame content, back-pressure,
// snapshot freeze, start while busy, reset mid-frame and checksum wrap.
module tb_reg_dump_serializer;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [1023:0] i_registers_debug;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic          o_busy;
   logic          o_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] frame[$];
   logic [7:0] exp_q[$];
   int         done_count;
   int         done_iter;
   int         stall_viol;
   int         stall_cycles;
   bit         timed_out;

   reg_dump_serializer #(.SIZE(32), .NUM_REGISTERS(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_start           (i_start),
      .i_registers_debug (i_registers_debug),
      .o_tx_data         (o_tx_data),
      .o_tx_valid        (o_tx_valid),
      .i_tx_ready        (i_tx_ready),
      .o_busy            (o_busy),
      .o_done            (o_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void build_expected(input logic [1023:0] img);
      logic [7:0] sum;
      logic [7:0] b;
      sum = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int r = 0; r < 32; r++)
         for (int k = 0; k < 4; k++) begin
            b = img[r*32 + 31 - 8*k -: 8];
            exp_q.push_back(b);
            sum = sum + b;
         end
      exp_q.push_back(sum);
   endfunction

   // Drives ready/start per cycle and records every transferred byte until o_done.
   // mode 0: ready held high; mode 1: random ready with a 5-cycle stall at byte 6.
   task automatic run_frame(input int mode, input int start_at, input int rst_at,
                            input int max_cycles);
      int         hold;
      bit         hold_done;
      bit         start_done;
      bit         prev_stall;
      logic [7:0] prev_data;
      frame.delete();
      done_count   = 0;
      done_iter    = -1;
      stall_viol   = 0;
      stall_cycles = 0;
      timed_out    = 1'b1;
      hold         = 0;
      hold_done    = 1'b0;
      start_done   = 1'b0;
      prev_stall   = 1'b0;
      prev_data    = 8'h00;
      for (int it = 0; it < max_cycles; it++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (start_at >= 0 && frame.size() == start_at && !start_done) begin
            i_start    = 1'b1;
            start_done = 1'b1;
         end
         if (rst_at >= 0 && frame.size() == rst_at) begin
            rst       = 1'b1;
            timed_out = 1'b0;
            return;
         end
         if (mode == 0) begin
            i_tx_ready = 1'b1;
         end else begin
            if (frame.size() == 6 && !hold_done) begin
               hold      = 5;
               hold_done = 1'b1;
            end
            if (hold > 0) begin
               i_tx_ready = 1'b0;
               hold--;
            end else begin
               i_tx_ready = 1'($urandom_range(0, 1));
            end
         end
         #1;
         if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) stall_viol++;
         if (o_tx_valid && !i_tx_ready) stall_cycles++;
         if (o_done === 1'b1) begin
            done_count++;
            done_iter = it;
            timed_out = 1'b0;
            return;
         end
         if (o_tx_valid && i_tx_ready) frame.push_back(o_tx_data);
         prev_stall = o_tx_valid && !i_tx_ready;
         prev_data  = o_tx_data;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      i_start = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_start = 1'b0; i_tx_ready = 1'b1; i_registers_debug = '0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (o_tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_tx_valid); end
      vectors++; if (o_tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", o_tx_data); end
      vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", o_done); end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++; $display("FAIL idle_ready_no_effect: valid=%b busy=%b want 0 0", o_tx_valid, o_busy);
      end
   endtask

   task automatic test_basic_frame();
      i_registers_debug = '0;
      i_registers_debug[32 +: 32] = 32'h11223344;
      build_expected(i_registers_debug);
      pulse_start();
      run_frame(0, -1, -1, 400);
      vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout: no o_done within 400 cycles"); end
      vectors++; if (frame.size() != 130) begin miscompares++; $display("FAIL basic_len: got %0d want 130", frame.size()); end
      vectors++; if (done_iter != 130) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want 130", done_iter); end
      if (frame.size() == 130) begin
         vectors++; if (frame[0] !== 8'hA5) begin miscompares++; $display("FAIL basic_header: got %h want a5", frame[0]); end
         vectors++; if ({frame[5], frame[6], frame[7], frame[8]} !== 32'h11223344) begin
            miscompares++; $display("FAIL basic_r1: got %h%h%h%h want 11223344", frame[5], frame[6], frame[7], frame[8]);
         end
         vectors++; if (frame[129] !== 8'hAA) begin miscompares++; $display("FAIL basic_checksum: got %h want aa", frame[129]); end
         for (int i = 0; i < 130; i++) begin
            vectors++; if (frame[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_byte[%0d]: got %h want %h", i, frame[i], exp_q[i]); end
         end
      end
      @(negedge clk); #1;
      vectors++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         miscompares++; $display("FAIL basic_after_done: busy=%b done=%b want 0 0", o_busy, o_done);
      end
   endtask

   task automatic test_back_pressure();
      i_registers_debug = '0;
      i_registers_debug[32 +: 32] = 32'h11223344;
      build_expected(i_registers_debug);
      pulse_start();
      run_frame(1, -1, -1, 2000);
      vectors++; if (timed_out) begin miscompares++; $display("FAIL bp_timeout: no o_done within 2000 cycles"); end
      vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stall_stable: %0d violations want 0", stall_viol); end
      vectors++; if (stall_cycles < 5) begin miscompares++; $display("FAIL bp_stalls_seen: got %0d want >=5", stall_cycles); end
      vectors++; if (frame.size() != 130) begin miscompares++; $display("FAIL bp_len: got %0d want 130", frame.size()); end
      if (frame.size() == 130)
         for (int i = 0; i < 130; i++) begin
            vectors++; if (frame[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_byte[%0d]: got %h want %h", i, frame[i], exp_q[i]); end
         end
   endtask

   task automatic test_snapshot_freeze();
      i_registers_debug = '0;
      i_registers_debug[32 +: 32] = 32'h11223344;
      @(negedge clk);
      i_start = 1'b1; i_tx_ready = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      i_registers_debug[32 +: 32] = 32'hFFFFFFFF;
      #1;
      vectors++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA5) begin
         miscompares++; $display("FAIL freeze_header_hold: valid=%b data=%h want 1 a5", o_tx_valid, o_tx_data);
      end
      run_frame(0, -1, -1, 400);
      vectors++; if (frame.size() != 130) begin miscompares++; $display("FAIL freeze_len: got %0d want 130", frame.size()); end
      if (frame.size() == 130) begin
         vectors++; if ({frame[5], frame[6], frame[7], frame[8]} !== 32'h11223344) begin
            miscompares++; $display("FAIL freeze_r1: got %h%h%h%h want 11223344", frame[5], frame[6], frame[7], frame[8]);
         end
         vectors++; if (frame[129] !== 8'hAA) begin miscompares++; $display("FAIL freeze_checksum: got %h want aa", frame[129]); end
      end
   endtask

   task automatic test_start_while_busy();
      int extra;
      i_registers_debug = '0;
      i_registers_debug[32 +: 32] = 32'h11223344;
      pulse_start();
      run_frame(0, 50, -1, 400);
      vectors++; if (frame.size() != 130 || done_count != 1) begin
         miscompares++; $display("FAIL busy_start_frame: len=%0d done=%0d want 130 1", frame.size(), done_count);
      end
      extra = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (o_tx_valid || o_done || o_busy) extra++;
      end
      vectors++; if (extra != 0) begin miscompares++; $display("FAIL busy_start_no_second: %0d active cycles want 0", extra); end
   endtask

   task automatic test_reset_mid_frame();
      i_registers_debug = '0;
      i_registers_debug[32 +: 32] = 32'h11223344;
      build_expected(i_registers_debug);
      pulse_start();
      run_frame(0, -1, 21, 400);
      @(negedge clk);
      rst = 1'b0; i_tx_ready = 1'b1;
      #1;
      vectors++; if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid_abort: valid=%b busy=%b want 0 0", o_tx_valid, o_busy);
      end
      pulse_start();
      run_frame(0, -1, -1, 400);
      vectors++; if (frame.size() != 130) begin miscompares++; $display("FAIL rst_restart_len: got %0d want 130", frame.size()); end
      if (frame.size() == 130) begin
         vectors++; if (frame[0] !== 8'hA5) begin miscompares++; $display("FAIL rst_restart_header: got %h want a5", frame[0]); end
         vectors++; if (frame[129] !== 8'hAA) begin miscompares++; $display("FAIL rst_restart_checksum: got %h want aa", frame[129]); end
      end
   endtask

   task automatic test_checksum_wrap();
      i_registers_debug = '0;
      i_registers_debug[0 +: 32]   = 32'hFFFFFFFF;
      i_registers_debug[992 +: 32] = 32'h01000000;
      pulse_start();
      run_frame(0, -1, -1, 400);
      vectors++; if (frame.size() != 130) begin miscompares++; $display("FAIL wrap_len: got %0d want 130", frame.size()); end
      if (frame.size() == 130) begin
         vectors++; if ({frame[1], frame[2], frame[3], frame[4]} !== 32'hFFFFFFFF) begin
            miscompares++; $display("FAIL wrap_r0: got %h%h%h%h want ffffffff", frame[1], frame[2], frame[3], frame[4]);
         end
         vectors++; if ({frame[125], frame[126], frame[127], frame[128]} !== 32'h01000000) begin
            miscompares++; $display("FAIL wrap_r31: got %h%h%h%h want 01000000", frame[125], frame[126], frame[127], frame[128]);
         end
         vectors++; if (frame[129] !== 8'hFD) begin miscompares++; $display("FAIL wrap_checksum: got %h want fd", frame[129]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_pressure();
      test_snapshot_freeze();
      test_start_while_busy();
      test_reset_mid_frame();
      test_checksum_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
